// File: rtl/react_pkg.sv
// react_pkg: shared state encoding, BCD limits and LFSR tap mask for reaction_ctrl.
package react_pkg;
    typedef enum logic [2:0] {IDLE, ARMED, TIMING, DONE, FAULT} state_e;
    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [7:0] BEST_INIT = 8'h99;
    // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/reaction_ctrl_bcd2_counter.sv
// bcd2_counter: two-digit BCD counter with synchronous clear, saturating at 99.
module bcd2_counter import react_pkg::*; (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o,
    output logic       max_o
);
    logic [3:0] tens_q, units_q;
    assign max_o   = (tens_q == BCD_MAX) && (units_q == BCD_MAX);
    assign tens_o  = tens_q;
    assign units_o = units_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tens_q  <= '0;
            units_q <= '0;
        end else if (clr_i) begin
            tens_q  <= '0;
            units_q <= '0;
        end else if (en_i && !max_o) begin
            units_q <= (units_q == BCD_MAX) ? 4'd0 : units_q + 4'd1;
            tens_q  <= (units_q == BCD_MAX) ? tens_q + 4'd1 : tens_q;
        end
    end
endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: reaction-time game controller (random delay, LED, BCD score).
// Define REACT_BEST_EN to keep a best-score register; otherwise Best reads 99.
module reaction_ctrl import react_pkg::*; #(
    parameter int unsigned MIN_DELAY = 100,
    parameter int unsigned RAND_BITS = 8,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Start,
    input  logic       Pushn,
    input  logic       Tick,
    output logic       LEDn,
    output logic [3:0] Score1,
    output logic [3:0] Score0,
    output logic [3:0] Best1,
    output logic [3:0] Best0,
    output logic       FalseStart,
    output logic       Busy
);
    state_e     state_q, state_d;
    logic [7:0] lfsr_q;
    logic [9:0] delay_q, delay_d;
    logic       s1_q, s2_q, s3_q, press;
    logic       led_n_q, busy_q, fs_q;
    logic       sc_clr, sc_en, sc_max;

    assign press      = s3_q & ~s2_q;
    assign LEDn       = led_n_q;
    assign Busy       = busy_q;
    assign FalseStart = fs_q;

    bcd2_counter u_score (
        .clk_i  (Clock),
        .rst_ni (Resetn),
        .clr_i  (sc_clr),
        .en_i   (sc_en),
        .tens_o (Score1),
        .units_o(Score0),
        .max_o  (sc_max)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            delay_q <= '0;
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            s3_q    <= 1'b1;
            led_n_q <= 1'b1;
            busy_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
            delay_q <= delay_d;
            s1_q    <= Pushn;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            led_n_q <= state_d != TIMING;
            busy_q  <= (state_d == ARMED) || (state_d == TIMING);
            fs_q    <= state_d == FAULT;
        end
    end

    // A press always takes priority over a simultaneous expiry or Tick
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        sc_clr  = 1'b0;
        sc_en   = 1'b0;
        case (state_q)
            ARMED: begin
                if (press) state_d = FAULT;
                else if (Tick) begin
                    delay_d = delay_q - 10'd1;
                    if (delay_q == 10'd1) state_d = TIMING;
                end
            end
            TIMING: begin
                if (press) state_d = DONE;
                else if (Tick) begin
                    state_d = sc_max ? DONE : TIMING;
                    sc_en   = !sc_max;
                end
            end
            default: begin
                if (Start) begin
                    state_d = ARMED;
                    delay_d = 10'(MIN_DELAY) + 10'(lfsr_q[RAND_BITS-1:0]);
                    sc_clr  = 1'b1;
                end
            end
        endcase
    end

`ifdef REACT_BEST_EN
    logic [7:0] best_q;
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) best_q <= BEST_INIT;
        else if (state_q == TIMING && state_d == DONE && {Score1, Score0} < best_q)
            best_q <= {Score1, Score0};
    end
    assign {Best1, Best0} = best_q;
`else
    assign Best1 = BCD_MAX;
    assign Best0 = BCD_MAX;
`endif
endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl: directed scenarios plus random play against a behavioural model.
module tb_reaction_ctrl;
    logic       Clock = 0, Resetn = 0, Start = 0, Pushn = 1, Tick = 0;
    logic       LEDn, FalseStart, Busy;
    logic [3:0] Score1, Score0, Best1, Best0;
    int vectors = 0, miscompares = 0;
    bit chk_en = 0;

    localparam int M_IDLE = 0, M_ARMED = 1, M_TIMING = 2, M_DONE = 3, M_FAULT = 4;
    int   m_mode, m_delay, m_score, m_best;
    logic [7:0] m_lfsr;
    logic ph0, ph1, ph2;

    reaction_ctrl dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Pushn(Pushn), .Tick(Tick),
        .LEDn(LEDn), .Score1(Score1), .Score0(Score0), .Best1(Best1), .Best0(Best0),
        .FalseStart(FalseStart), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            m_mode = M_IDLE; m_delay = 0; m_score = 0; m_best = 99;
            m_lfsr = 8'hA5; ph0 = 1; ph1 = 1; ph2 = 1;
        end else begin
            logic press;
            press = ph2 && !ph1;
            case (m_mode)
                M_ARMED:
                    if (press) m_mode = M_FAULT;
                    else if (Tick) begin
                        m_delay = m_delay - 1;
                        if (m_delay == 0) m_mode = M_TIMING;
                    end
                M_TIMING:
                    if (press || (Tick && m_score == 99)) begin
                        m_mode = M_DONE;
`ifdef REACT_BEST_EN
                        if (m_score < m_best) m_best = m_score;
`endif
                    end else if (Tick) m_score = m_score + 1;
                default:
                    if (Start) begin
                        m_mode = M_ARMED;
                        m_delay = 100 + int'(m_lfsr);
                        m_score = 0;
                    end
            endcase
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            ph2 = ph1; ph1 = ph0; ph0 = Pushn;
        end
    end

    always @(negedge Clock) begin
        if (chk_en) begin
            logic [7:0] es, eb;
            logic el, ef, ebz;
            es  = bcd(m_score);
            eb  = bcd(m_best);
            el  = m_mode != M_TIMING;
            ef  = m_mode == M_FAULT;
            ebz = m_mode == M_ARMED || m_mode == M_TIMING;
            vectors++;
            if ({Score1, Score0} !== es || {Best1, Best0} !== eb || LEDn !== el ||
                FalseStart !== ef || Busy !== ebz) begin
                miscompares++;
                $display("FAIL model t=%0t score=%h/%h best=%h/%h led=%b fs=%b busy=%b expected score=%h best=%h led=%b fs=%b busy=%b",
                         $time, Score1, Score0, Best1, Best0, LEDn, FalseStart, Busy, es, eb, el, ef, ebz);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic pn, input logic tk);
        Start = st; Pushn = pn; Tick = tk;
        @(posedge Clock);
        #1;
    endtask

    task automatic tick_to_timing();
        int n = 0;
        while (m_mode != M_TIMING && n < 2000) begin cyc(0, 1, 1); n++; end
        chk("reach_timing", m_mode, M_TIMING);
    endtask

    int exp_best;

    initial begin
        @(posedge Clock); @(posedge Clock); #1;
        Resetn = 1;
        chk_en = 1;
        chk("rst_led", LEDn, 1);
        chk("rst_score", {Score1, Score0}, 8'h00);
        chk("rst_best", {Best1, Best0}, 8'h99);
        chk("rst_busy", Busy, 0);
        // first trial: delay 100+0xA5 = 265 ticks
        cyc(1, 1, 0);
        chk("armed_busy", Busy, 1);
        repeat (264) cyc(0, 1, 1);
        chk("led_before_265", LEDn, 1);
        cyc(0, 1, 1);
        chk("led_at_265", LEDn, 0);
        repeat (37) cyc(0, 1, 1);
        cyc(0, 0, 0); cyc(0, 0, 0);
        chk("led_press_latency", LEDn, 0);
        cyc(0, 0, 0);
        chk("score_37", {Score1, Score0}, 8'h37);
        chk("done_led", LEDn, 1);
        chk("done_busy", Busy, 0);
`ifdef REACT_BEST_EN
        exp_best = 8'h37;
`else
        exp_best = 8'h99;
`endif
        chk("best_37", {Best1, Best0}, exp_best);
        // false start
        cyc(1, 0, 0);
        repeat (3) cyc(0, 1, 0);
        repeat (3) cyc(0, 0, 0);
        chk("fault_fs", FalseStart, 1);
        chk("fault_led", LEDn, 1);
        chk("fault_best", {Best1, Best0}, exp_best);
        cyc(1, 0, 0);
        chk("restart_fs", FalseStart, 0);
        chk("restart_busy", Busy, 1);
        repeat (3) cyc(0, 1, 0);
        // no press: saturate at 99
        tick_to_timing();
        repeat (99) cyc(0, 1, 1);
        chk("score_99_busy", Busy, 1);
        cyc(0, 1, 1);
        chk("sat_score", {Score1, Score0}, 8'h99);
        chk("sat_busy", Busy, 0);
        chk("sat_best", {Best1, Best0}, exp_best);
        // press coincides with expiry
        cyc(1, 1, 0);
        for (int n = 0; n < 2000 && m_delay != 3; n++) cyc(0, 1, 1);
        repeat (3) cyc(0, 0, 1);
        chk("press_expiry_fs", FalseStart, 1);
        chk("press_expiry_led", LEDn, 1);
        // press coincides with tick at score 12
        cyc(1, 0, 0);
        repeat (3) cyc(0, 1, 0);
        tick_to_timing();
        repeat (12) cyc(0, 1, 1);
        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 1);
        chk("press_tick_score", {Score1, Score0}, 8'h12);
`ifdef REACT_BEST_EN
        exp_best = 8'h12;
`endif
        chk("press_tick_best", {Best1, Best0}, exp_best);
        // reset mid-TIMING
        cyc(1, 1, 0);
        tick_to_timing();
        repeat (5) cyc(0, 1, 1);
        #2 Resetn = 0;
        #1;
        chk("arst_led", LEDn, 1);
        chk("arst_score", {Score1, Score0}, 8'h00);
        chk("arst_best", {Best1, Best0}, 8'h99);
        chk("arst_busy", Busy, 0);
        @(posedge Clock); #1 Resetn = 1;
        // random play
        for (int i = 0; i < 30000; i++) begin
            logic st, pn, tk;
            int pr;
            pr = (m_mode == M_ARMED) ? 600 : 24;
            st = ($urandom % 48) == 0;
            tk = ($urandom % 4) != 0;
            pn = (($urandom % pr) == 0) ? ~Pushn : Pushn;
            if (($urandom % 6000) == 0) begin
                Start = st; Pushn = pn; Tick = tk;
                #3 Resetn = 0;
                @(posedge Clock); #1 Resetn = 1;
            end else cyc(st, pn, tk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
